// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl
//   Decode-stage controller that sits between IF and EX and sequences the
//   immediate generator. One instruction is held in a pipeline register
//   together with its PC and registered opcode classification. The held
//   values stay stable until EX accepts the instruction.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     IF handshake (in_ready is combinational)
//   in_instr, in_pc       fetched instruction word and its PC
//   flush                 redirect: drop held and incoming instructions
//   out_valid/out_ready   EX handshake
//   out_instr, out_pc     held instruction (feeds immediate generator) and PC
//   ext_op                immediate format: 000 I, 001 U, 010 S, 011 B, 100 J
//   imm_used              held instruction consumes an immediate
//   illegal               held opcode not recognised
//   stall_cnt             saturating count of out_valid && !out_ready cycles
module imm_decode_ctrl #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [2:0]       ext_op,
  output logic             imm_used,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_U = 3'b001,
    EXT_S = 3'b010,
    EXT_B = 3'b011,
    EXT_J = 3'b100
  } ext_e;

  ext_e dec_ext;
  logic dec_imm;
  logic dec_ill;
  ext_e ext_q;
  logic accept;
  logic handoff;

  // rst_n gating keeps in_ready low for the whole reset window.
  assign in_ready = rst_n && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;
  assign ext_op   = ext_q;

  // Opcode classification; every legal opcode ends in 2'b11, so any other
  // low-bit pattern falls through to the illegal default.
  always_comb begin
    dec_ext = EXT_I;
    dec_imm = 1'b0;
    dec_ill = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011,
      7'b1100111, 7'b1110011: begin dec_ext = EXT_I; dec_imm = 1'b1; end
      7'b0110111, 7'b0010111: begin dec_ext = EXT_U; dec_imm = 1'b1; end
      7'b0100011:             begin dec_ext = EXT_S; dec_imm = 1'b1; end
      7'b1100011:             begin dec_ext = EXT_B; dec_imm = 1'b1; end
      7'b1101111:             begin dec_ext = EXT_J; dec_imm = 1'b1; end
      7'b0110011, 7'b0111011: begin dec_ext = EXT_I; dec_imm = 1'b0; end
      default:                dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      ext_q     <= EXT_I;
      imm_used  <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_instr <= in_instr;
      out_pc    <= in_pc;
      ext_q     <= dec_ext;
      imm_used  <= dec_imm;
      illegal   <= dec_ill;
    end else if (handoff) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
- Decode-stage controller that sequences the immediate generator between IF and EX.
- Accepts instructions from IF over a valid/ready handshake and holds each one in a pipeline register.
- Classifies the opcode into the 3-bit ExtOP immediate-format select and presents instr/ExtOP, aligned and stable, to the immediate generator until EX accepts.
- Handles back-pressure, pipeline flush, illegal-opcode flagging and a stall counter.

Parameters:
- PC_W, 64, width of the program counter carried alongside the instruction.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  IF holds a valid instruction.
- in_ready  output  1  block accepts an instruction this cycle.
- in_instr  input  32  fetched instruction word.
- in_pc  input  PC_W  PC of in_instr.
- flush  input  1  redirect: discard held and incoming instructions.
- out_valid  output  1  held instruction is valid for EX.
- out_ready  input  1  EX accepts this cycle.
- out_instr  output  32  held instruction; drives the immediate generator instr input.
- out_pc  output  PC_W  held PC.
- ext_op  output  3  immediate format select: 000 I, 001 U, 010 S, 011 B, 100 J.
- imm_used  output  1  held instruction consumes an immediate.
- illegal  output  1  held opcode is not recognised.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, out_instr=0, out_pc=0, ext_op=000, imm_used=0, illegal=0, stall_cnt=0.
  - in_ready reads 0 while rst_n=0.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Hand off when out_valid && out_ready.
- in_ready = !flush && (!out_valid || out_ready), combinational. This gives full throughput of 1 instruction/cycle.
- Latency: an instruction accepted at edge N appears on out_* and ext_op in the cycle after edge N (1 cycle).
- Output stability: while out_valid && !out_ready, out_instr, out_pc, ext_op, imm_used and illegal hold constant. The immediate generator output stays stable for EX.
- Decode is on in_instr[6:0] and is registered with the instruction:
  - 0000011, 0010011, 0011011, 1100111, 1110011 -> ext_op 000, imm_used 1.
  - 0110111, 0010111 -> 001, imm_used 1.
  - 0100011 -> 010, imm_used 1.
  - 1100011 -> 011, imm_used 1.
  - 1101111 -> 100, imm_used 1.
  - 0110011, 0111011 -> 000, imm_used 0.
  - Any other opcode -> 000, imm_used 0, illegal 1. The instruction is still passed downstream with out_valid=1.
  - The low two bits are not 11 -> illegal 1.
- Register update at each clk edge, in priority order:
  1. flush=1: out_valid<=0. Data registers may hold. Nothing is accepted. Flush overrides simultaneous in_valid and out_ready.
  2. Accept: load instr, pc and decode results; out_valid<=1. This covers the simultaneous hand-off-and-accept case.
  3. Hand off without accept: out_valid<=0. Data registers hold.
  4. Otherwise hold.
- stall_cnt:
  - Increments by 1 each cycle with out_valid && !out_ready && !flush.
  - Saturates at all-ones; no wrap.
  - Cleared only by reset.
- Reset mid-operation: held instruction is dropped immediately. Nothing is emitted after release until a new accept.
- No combinational path from out_ready/flush to out_* data. in_ready is the only combinational output.

Test Plan:
- Reset, then in_valid=1 with 0x00500093 (addi), out_ready=1 -> next cycle out_valid=1, ext_op=000, imm_used=1, illegal=0, out_instr=0x00500093.
- Back-to-back stream 0x12345037 (lui), 0x00112023 (sw), 0x00000063 (beq), 0x0000006f (jal), out_ready=1 -> ext_op sequence 001, 010, 011, 100 on consecutive cycles, in_ready=1 throughout.
- Hold sw (0x00112023) with out_ready=0 for 5 cycles -> in_ready=0, outputs stable, ext_op=010, stall_cnt=5; then out_ready=1 with new in_valid -> new instruction loaded the same edge.
- out_valid=1, then flush=1 together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready was 0 during flush, stall_cnt unchanged.
- 0x00000033 (add) -> imm_used=0, illegal=0, ext_op=000; 0x0000007f -> illegal=1, out_valid=1.
- Assert rst_n=0 asynchronously mid-stall -> out_valid and stall_cnt go to 0 before the next edge; after release no output until the next accept.
